sevenseg_scan_decoder: RTL and testbench

Receive-side counterpart of the hex-to-seven-segment encoder: it watches a time-multiplexed seven-segment bus (segment lines plus one-hot digit strobes), waits for each strobed pattern to settle, and decodes it back to a 4-bit hex nibble. Decoded digits are assembled into a multi-digit word, which is published with a one-cycle valid pulse once every digit of a frame has been captured. It sits on the ALU board-I/O path for self-check and loopback of the display output, and for test-bench observation of that output.

---
 rtl/sevenseg_pkg.sv | 37 +++
 rtl/sevenseg_scan_decoder_if.sv | 23 ++
 rtl/sevenseg_pattern_decode.sv | 34 +++
 rtl/sevenseg_scan_decoder.sv | 180 ++++++++++++++++++
 tb/tb_sevenseg_scan_decoder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types, active-low segment codes and FSM states for the seven-segment scan decoder.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  // Active-low patterns, bit0=a ... bit6=g.
  localparam seg_t SEG_0 = 7'h40;
  localparam seg_t SEG_1 = 7'h79;
  localparam seg_t SEG_2 = 7'h24;
  localparam seg_t SEG_3 = 7'h30;
  localparam seg_t SEG_4 = 7'h19;
  localparam seg_t SEG_5 = 7'h12;
  localparam seg_t SEG_6 = 7'h02;
  localparam seg_t SEG_7 = 7'h78;
  localparam seg_t SEG_8 = 7'h00;
  localparam seg_t SEG_9 = 7'h10;
  localparam seg_t SEG_A = 7'h08;
  localparam seg_t SEG_B = 7'h03;
  localparam seg_t SEG_C = 7'h46;
  localparam seg_t SEG_D = 7'h21;
  localparam seg_t SEG_E = 7'h06;
  localparam seg_t SEG_F = 7'h0E;

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_e;

  // Index of the highest set bit; callers only pass one-hot vectors.
  function automatic logic [2:0] onehot_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_if.sv
// Bus bundle between a seven-segment display driver (master) and the scan decoder (slave).
interface sevenseg_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic                    clear;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    frame_valid;
  logic [NUM_DIGITS-1:0]   slot_mask;
  logic                    err;
  logic [2:0]              err_digit;

  modport master (
    output seg_n, dig_en, clear,
    input  value, frame_valid, slot_mask, err, err_digit
  );

  modport slave (
    input  seg_n, dig_en, clear,
    output value, frame_valid, slot_mask, err, err_digit
  );
endinterface

// File: rtl/sevenseg_pattern_decode.sv
// Combinational active-low seven-segment pattern to hex nibble decoder.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  seg_t    seg_i,
  output nibble_t nibble_o,
  output logic    valid_o
);

  always_comb begin
    nibble_o = '0;
    valid_o  = 1'b1;
    case (seg_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Settles and decodes a multiplexed seven-segment bus into a multi-digit hex word.
// Define SEVENSEG_ERR_EN to enable sticky invalid-pattern reporting (err / err_digit).
module sevenseg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  sevenseg_scan_decoder_if.slave bus
);

  localparam int unsigned SW = NUM_DIGITS + 7;
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CntMax  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  logic [SW-1:0] sample_d, sample_q;
  state_e        state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          onehot, same, capture;

  assign sample_d = {bus.dig_en, bus.seg_n};
  assign onehot   = $onehot(bus.dig_en);
  assign same     = (sample_d == sample_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
    end
  end

  // Next-state logic; any non-one-hot strobe is a blanking interval.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!onehot) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SETTLE;
          cnt_d   = CntOne;
        end
        SETTLE: begin
          if (!same) begin
            cnt_d = CntOne;
          end else if (cnt_q == CntLast) begin
            state_d = HELD;
            cnt_d   = CntMax;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        HELD: begin
          if (!same) begin
            state_d = SETTLE;
            cnt_d   = CntOne;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output logic: single capture strobe on the edge that completes settling.
  always_comb begin
    capture = 1'b0;
    if (onehot && same && (state_q == SETTLE) && (cnt_q == CntLast)) begin
      capture = 1'b1;
    end
  end

  nibble_t dec_nibble;
  logic    dec_valid;

  sevenseg_pattern_decode u_decode (
    .seg_i    (bus.seg_n),
    .nibble_o (dec_nibble),
    .valid_o  (dec_valid)
  );

  nibble_t                 slot_d [NUM_DIGITS];
  nibble_t                 slot_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   mask_d, mask_q;
  logic [4*NUM_DIGITS-1:0] value_d, value_q;
  logic                    fv_d, fv_q;

  always_comb begin
    slot_d  = slot_q;
    mask_d  = mask_q;
    value_d = value_q;
    fv_d    = 1'b0;
    if (bus.clear) begin
      mask_d = '0;
    end else if (capture && dec_valid) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (bus.dig_en[i]) begin
          slot_d[i] = dec_nibble;
          mask_d[i] = 1'b1;
        end
      end
      if (&mask_d) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          value_d[4*i +: 4] = slot_d[i];
        end
        fv_d   = 1'b1;
        mask_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) slot_q[i] <= '0;
      mask_q  <= '0;
      value_q <= '0;
      fv_q    <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      fv_q    <= fv_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.frame_valid = fv_q;
  assign bus.slot_mask   = mask_q;

`ifdef SEVENSEG_ERR_EN
  logic       err_d, err_q;
  logic [2:0] err_digit_d, err_digit_q;
  logic [2:0] slot_idx;

  assign slot_idx = onehot_index(8'(bus.dig_en));

  // Only the first offending digit is recorded until err is cleared.
  always_comb begin
    err_d       = err_q;
    err_digit_d = err_digit_q;
    if (bus.clear) begin
      err_d = 1'b0;
    end else if (capture && !dec_valid && !err_q) begin
      err_d       = 1'b1;
      err_digit_d = slot_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
    end
  end

  assign bus.err       = err_q;
  assign bus.err_digit = err_digit_q;
`else
  assign bus.err       = 1'b0;
  assign bus.err_digit = 3'b000;
`endif

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Directed self-checking bench for sevenseg_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=4).
module tb_sevenseg_scan_decoder;
  import sevenseg_pkg::*;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 4;
`ifdef SEVENSEG_ERR_EN
  localparam logic [31:0] ExpErr    = 32'd1;
  localparam logic [31:0] ExpErrDig = 32'd1;
`else
  localparam logic [31:0] ExpErr    = 32'd0;
  localparam logic [31:0] ExpErrDig = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sevenseg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  sevenseg_scan_decoder #(
    .NUM_DIGITS    (ND),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_bad   = 0;
  int fv_seen = 0;

  always @(negedge clk) if (bus.frame_valid === 1'b1) fv_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] dig, input logic [6:0] seg);
    bus.dig_en = dig;
    bus.seg_n  = seg;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [3:0] dig, input logic [6:0] seg, input int n);
    repeat (n) step(dig, seg);
  endtask

  initial begin
    bus.dig_en = '0;
    bus.seg_n  = 7'h7F;
    bus.clear  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset asserted mid-settle
    hold(4'b0001, 7'h40, 2);
    rst_n = 1'b0;
    #1;
    chk("rst_value", 32'(bus.value), 32'h0);
    chk("rst_fv", 32'(bus.frame_valid), 32'h0);
    chk("rst_mask", 32'(bus.slot_mask), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_err_digit", 32'(bus.err_digit), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    hold(4'b0001, 7'h40, 2);
    rst_n = 1'b1;
    hold(4'b0001, 7'h40, 3);
    chk("post_rst_early", 32'(bus.slot_mask), 32'h0);
    step(4'b0001, 7'h40);
    chk("post_rst_cap", 32'(bus.slot_mask), 32'h1);

    // Full frame 0,1,A,F with blanking between digits
    hold(4'b0001, 7'h40, 2);
    step(4'b0000, 7'h7F);
    hold(4'b0010, 7'h79, 6);
    step(4'b0000, 7'h7F);
    hold(4'b0100, 7'h08, 6);
    step(4'b0000, 7'h7F);
    hold(4'b1000, 7'h0E, 3);
    chk("f1_mask_pre", 32'(bus.slot_mask), 32'h7);
    chk("f1_fv_pre", 32'(bus.frame_valid), 32'h0);
    step(4'b1000, 7'h0E);
    chk("f1_fv", 32'(bus.frame_valid), 32'h1);
    chk("f1_value", 32'(bus.value), 32'hFA10);
    chk("f1_mask", 32'(bus.slot_mask), 32'h0);
    step(4'b1000, 7'h0E);
    chk("f1_fv_drop", 32'(bus.frame_valid), 32'h0);
    chk("f1_value_keep", 32'(bus.value), 32'hFA10);
    hold(4'b1000, 7'h0E, 2);
    chk("f1_no_recap", 32'(bus.slot_mask), 32'h0);
    step(4'b0000, 7'h7F);

    // Glitch on digit 2: 24 twice then 30; capture on 4th cycle of 30
    hold(4'b0100, 7'h24, 2);
    hold(4'b0100, 7'h30, 3);
    chk("glitch_early", 32'(bus.slot_mask), 32'h0);
    step(4'b0100, 7'h30);
    chk("glitch_cap", 32'(bus.slot_mask), 32'h4);
    step(4'b0000, 7'h7F);

    // Back-to-back digits without blanking: 5, 6, 7
    hold(4'b0001, 7'h12, 4);
    chk("b2b_d0", 32'(bus.slot_mask), 32'h5);
    hold(4'b0010, 7'h02, 4);
    chk("b2b_d1", 32'(bus.slot_mask), 32'h7);
    hold(4'b1000, 7'h78, 3);
    step(4'b1000, 7'h78);
    chk("f2_fv", 32'(bus.frame_valid), 32'h1);
    chk("f2_value", 32'(bus.value), 32'h7365);
    chk("f2_mask", 32'(bus.slot_mask), 32'h0);
    step(4'b0000, 7'h7F);

    // Invalid pattern on digit 1
    hold(4'b0010, 7'h7F, 4);
    chk("inv_mask", 32'(bus.slot_mask), 32'h0);
    chk("inv_err", 32'(bus.err), ExpErr);
    chk("inv_err_digit", 32'(bus.err_digit), ExpErrDig);
    hold(4'b0010, 7'h7F, 2);
    chk("inv_no_fv", 32'(fv_seen), 32'd2);
    bus.clear = 1'b1;
    step(4'b0000, 7'h7F);
    bus.clear = 1'b0;
    chk("clr_err", 32'(bus.err), 32'h0);

    // Clear coincides with the final capture of a frame
    hold(4'b0001, 7'h00, 4);
    hold(4'b0010, 7'h10, 4);
    hold(4'b0100, 7'h46, 4);
    chk("sim_mask_pre", 32'(bus.slot_mask), 32'h7);
    hold(4'b1000, 7'h21, 3);
    bus.clear = 1'b1;
    step(4'b1000, 7'h21);
    bus.clear = 1'b0;
    chk("sim_fv", 32'(bus.frame_valid), 32'h0);
    chk("sim_mask", 32'(bus.slot_mask), 32'h0);
    chk("sim_value", 32'(bus.value), 32'h7365);
    step(4'b1000, 7'h21);
    chk("sim_held", 32'(bus.slot_mask), 32'h0);
    step(4'b0000, 7'h7F);

    // Multi-hot strobe is blanking
    for (int i = 0; i < 10; i++) begin
      step(4'b0011, 7'h40);
      chk("blank_state", 32'(dut.state_q), 32'(IDLE));
    end
    chk("blank_mask", 32'(bus.slot_mask), 32'h0);
    hold(4'b0001, 7'h40, 3);
    chk("after_blank_early", 32'(bus.slot_mask), 32'h0);
    step(4'b0001, 7'h40);
    chk("after_blank_cap", 32'(bus.slot_mask), 32'h1);

    chk("fv_total", 32'(fv_seen), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
